// File: rtl/static_arb.sv
// rtl/static_arb.sv - round-robin scheduler sharing one byte-popcount datapath across NUM_CH streams
// Optional stall abort enabled by defining STATIC_ARB_TIMEOUT_EN.
module static_arb #(
   parameter int NUM_CH    = 4,
   parameter int WORD_BITS = 256,
   parameter int CH_W      = $clog2(NUM_CH),
   parameter int CNT_W     = $clog2(WORD_BITS) + 1,
   parameter int TIMEOUT   = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_CH-1:0]   in_valid,
   input  logic [NUM_CH*8-1:0] in_data,
   output logic [NUM_CH-1:0]   in_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [CH_W-1:0]     res_ch,
   output logic [CNT_W-1:0]    res_ones,
   output logic [CNT_W-1:0]    res_zeros,
   output logic                res_err,
   output logic                busy
);
   localparam int BYTE_CNT = WORD_BITS / 8;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   if (NUM_CH < 2 || (WORD_BITS % 8) != 0 || WORD_BITS < 16 || TIMEOUT < 1) begin : g_bad_cfg
      $error("static_arb: illegal parameter set");
   end

   logic [1:0]       state_q, state_d;
   logic [CH_W-1:0]  grant_q, grant_d;
   logic [CH_W-1:0]  last_grant_q, last_grant_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CH_W-1:0]  res_ch_q, res_ch_d;
   logic [CNT_W-1:0] res_ones_q, res_ones_d;
   logic [CNT_W-1:0] res_zeros_q, res_zeros_d;
   logic             res_err_q, res_err_d;

   logic [CH_W-1:0]  pick;
   logic             any_req;
   logic [7:0]       gnt_byte;
   logic             beat;
   logic [CNT_W-1:0] acc_sum;
   logic             timeout_hit;

   function automatic logic [3:0] popcount8(input logic [7:0] b);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, b[i]};
      end
      return n;
   endfunction

   // Highest offset is visited first so the nearest requester after last_grant wins.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int off = NUM_CH; off >= 1; off--) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid[c] && (c == (int'(last_grant_q) + off) % NUM_CH)) begin
               pick    = CH_W'(c);
               any_req = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gnt_byte = '0;
      in_ready = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant_q == CH_W'(c)) begin
            gnt_byte    = in_data[8*c +: 8];
            in_ready[c] = (state_q == S_COLLECT);
         end
      end
   end

   assign beat    = |(in_valid & in_ready);
   assign acc_sum = acc_q + CNT_W'(popcount8(gnt_byte));

`ifdef STATIC_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] stall_q, stall_d;

   assign timeout_hit = (state_q == S_COLLECT) && !beat && (stall_q == TO_W'(TIMEOUT - 1));

   always_comb begin
      stall_d = stall_q;
      if (state_q != S_COLLECT || beat) begin
         stall_d = '0;
      end else begin
         stall_d = stall_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      acc_d        = acc_q;
      beat_cnt_d   = beat_cnt_q;
      res_ch_d     = res_ch_q;
      res_ones_d   = res_ones_q;
      res_zeros_d  = res_zeros_q;
      res_err_d    = res_err_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant_d    = pick;
               acc_d      = '0;
               beat_cnt_d = '0;
               state_d    = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (beat) begin
               acc_d      = acc_sum;
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (beat_cnt_q == CNT_W'(BYTE_CNT - 1)) begin
                  res_ones_d  = acc_sum;
                  res_zeros_d = CNT_W'(WORD_BITS) - acc_sum;
                  res_ch_d    = grant_q;
                  res_err_d   = 1'b0;
                  state_d     = S_DONE;
               end
            end else if (timeout_hit) begin
               // Aborted window reports only the bytes actually received.
               res_ones_d  = acc_q;
               res_zeros_d = (beat_cnt_q << 3) - acc_q;
               res_ch_d    = grant_q;
               res_err_d   = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               last_grant_d = grant_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= CH_W'(NUM_CH - 1);
         acc_q        <= '0;
         beat_cnt_q   <= '0;
         res_ch_q     <= '0;
         res_ones_q   <= '0;
         res_zeros_q  <= '0;
         res_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         acc_q        <= acc_d;
         beat_cnt_q   <= beat_cnt_d;
         res_ch_q     <= res_ch_d;
         res_ones_q   <= res_ones_d;
         res_zeros_q  <= res_zeros_d;
         res_err_q    <= res_err_d;
      end
   end

   assign res_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign res_ch    = res_ch_q;
   assign res_ones  = res_ones_q;
   assign res_zeros = res_zeros_q;
   assign res_err   = res_err_q;

endmodule

// File: tb/tb_static_arb.sv
// tb/tb_static_arb.sv - directed self-checking bench for static_arb (NUM_CH=4, WORD_BITS=256)
module tb_static_arb;
   logic        clk;
   logic        rst;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_ch;
   logic [8:0]  res_ones;
   logic [8:0]  res_zeros;
   logic        res_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   static_arb dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_ch    (res_ch),
      .res_ones  (res_ones),
      .res_zeros (res_zeros),
      .res_err   (res_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Enters and returns on a negedge; valid is dropped on return.
   task automatic feed(input int ch, input logic [7:0] b, input int n, input bit gaps, output int cycles);
      int beats;
      bit v;
      bit other;
      bit early;
      logic [3:0] mask;
      beats  = 0;
      cycles = 0;
      other  = 1'b0;
      early  = 1'b0;
      mask   = 4'b0001 << ch;
      while (beats < n && cycles < 400) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_valid[ch]       = v;
         in_data[8*ch +: 8] = b;
         if ((in_ready & ~mask) != 4'b0000) other = 1'b1;
         if (res_valid) early = 1'b1;
         if (v && in_ready[ch]) beats++;
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      in_valid[ch] = 1'b0;
      check("feed_beats", beats, n);
      check("feed_ready_onehot", {31'd0, other}, 0);
      check("feed_no_early_res", {31'd0, early}, 0);
   endtask

   int cyc;
   int n_res;
   int rec_ch [5];
   int rec_ones [5];
   int rec_k [5];
   int exp_ch [5]   = '{0, 1, 2, 3, 0};
   int exp_ones [5] = '{0, 64, 96, 128, 0};
   bit flag;

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      res_ready = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_in_ready", in_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_ch", res_ch, 0);
      check("rst_res_ones", res_ones, 0);
      check("rst_res_zeros", res_zeros, 0);
      check("rst_res_err", res_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // ch0: 32 x 0xFF, valid held high
      feed(0, 8'hFF, 32, 1'b0, cyc);
      check("t1_cycles", cyc, 33);
      check("t1_res_valid", res_valid, 1);
      check("t1_res_ch", res_ch, 0);
      check("t1_res_ones", res_ones, 256);
      check("t1_res_zeros", res_zeros, 0);
      check("t1_res_err", res_err, 0);
      @(negedge clk);
      check("t1_idle_after_hs", busy, 0);
      check("t1_res_valid_drop", res_valid, 0);

      // ch1: 32 x 0x01 with random valid gaps
      feed(1, 8'h01, 32, 1'b1, cyc);
      check("t2_res_valid", res_valid, 1);
      check("t2_res_ch", res_ch, 1);
      check("t2_res_ones", res_ones, 32);
      check("t2_res_zeros", res_zeros, 224);
      @(negedge clk);

      // All channels requesting: round-robin order and 34-cycle windows
      do_reset();
      in_data  = {8'hAA, 8'h07, 8'h03, 8'h00};
      in_valid = 4'hF;
      n_res    = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (res_valid && n_res < 5) begin
            rec_ch[n_res]   = res_ch;
            rec_ones[n_res] = res_ones;
            rec_k[n_res]    = k;
            n_res++;
         end
      end
      in_valid = '0;
      check("t3_num_results", n_res, 5);
      check("t3_first_latency", rec_k[0], 32);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_ch_%0d", i), rec_ch[i], exp_ch[i]);
         check($sformatf("t3_ones_%0d", i), rec_ones[i], exp_ones[i]);
         if (i > 0) check($sformatf("t3_period_%0d", i), rec_k[i] - rec_k[i-1], 34);
      end

      // Back-pressure in DONE
      do_reset();
      res_ready = 1'b0;
      feed(0, 8'h55, 32, 1'b0, cyc);
      in_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         check("t4_hold_valid", res_valid, 1);
         check("t4_hold_ch", res_ch, 0);
         check("t4_hold_ones", res_ones, 128);
         check("t4_hold_zeros", res_zeros, 128);
         check("t4_hold_in_ready", in_ready, 0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      in_valid  = '0;
      @(negedge clk);
      check("t4_idle_after_ready", busy, 0);
      check("t4_res_valid_drop", res_valid, 0);

      // Reset mid-window on ch2
      do_reset();
      feed(2, 8'hFF, 10, 1'b0, cyc);
      rst = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_in_ready", in_ready, 0);
      check("t5_rst_res_valid", res_valid, 0);
      check("t5_rst_res_ones", res_ones, 0);
      @(negedge clk);
      rst  = 1'b0;
      flag = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid || busy) flag = 1'b1;
      end
      check("t5_no_result", {31'd0, flag}, 0);
      in_valid = 4'hF;
      @(posedge clk);
      @(negedge clk);
      check("t5_first_grant_ch0", in_ready, 4'b0001);
      in_valid = '0;
      do_reset();

`ifdef STATIC_ARB_TIMEOUT_EN
      // ch3: 5 x 0x0F then stall until abort
      feed(3, 8'h0F, 5, 1'b0, cyc);
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (k == 63) check("t6_no_early_abort", res_valid, 0);
      end
      check("t6_res_valid", res_valid, 1);
      check("t6_res_err", res_err, 1);
      check("t6_res_ch", res_ch, 3);
      check("t6_res_ones", res_ones, 20);
      check("t6_res_zeros", res_zeros, 20);
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
